// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters, holding each result until accepted
module alu_arbiter #(
  parameter bit          RR_EN  = 1'b1,
  parameter int unsigned MAX_OP = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op_0,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic [3:0]  req_op_1,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  input  logic [31:0] alu_result
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] max_op = 4'(MAX_OP);
  state_t state;
  logic   grant, rr_ptr, g, illegal;
  // pick the port to serve; ready is offered only while idle and out of reset
  always_comb begin
    g = RR_EN ? (&req_valid ? rr_ptr : req_valid[1]) : ~req_valid[0];
    req_ready = (state == IDLE && !rst && |req_valid) ? 2'b01 << g : 2'b00;
    illegal = alu_op > max_op;
  end
  // one op in flight: latch operands, capture result, hold response until the granted port takes it
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      rr_ptr    <= 1'b0;
      alu_op    <= '0;
      alu_op_a  <= '0;
      alu_op_b  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else
      case (state)
        IDLE: if (|req_valid) begin
          alu_op   <= g ? req_op_1 : req_op_0;
          alu_op_a <= g ? req_a_1 : req_a_0;
          alu_op_b <= g ? req_b_1 : req_b_0;
          grant    <= g;
          rr_ptr   <= ~g;
          state    <= EXEC;
        end
        EXEC: begin
          rsp_err   <= illegal;
          rsp_data  <= illegal ? '0 : alu_result;
          rsp_valid <= grant ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: if (rsp_ready[grant]) begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed corner sequences and randomized traffic against a transaction-level model
module tb_alu_arbiter;
  logic        clk, rst;
  logic [1:0]  req_valid, rsp_ready;
  logic [3:0]  req_op_0, req_op_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic [1:0]  req_ready, rsp_valid, f_req_ready, f_rsp_valid;
  logic [31:0] rsp_data, alu_op_a, alu_op_b, alu_result;
  logic [31:0] f_rsp_data, f_alu_op_a, f_alu_op_b, f_alu_result;
  logic        rsp_err, f_rsp_err;
  logic [3:0]  alu_op, f_alu_op;
  int          errs = 0, checks = 0;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic logic [32:0] expect_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op > 4'd6) ? {1'b1, 32'h0} : {1'b0, alu_f(op, a, b)};
  endfunction

  assign alu_result   = alu_f(alu_op, alu_op_a, alu_op_b);
  assign f_alu_result = alu_f(f_alu_op, f_alu_op_a, f_alu_op_b);

  alu_arbiter #(.RR_EN(1'b1), .MAX_OP(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_0(req_op_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_op_1(req_op_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_result(alu_result));

  alu_arbiter #(.RR_EN(1'b0), .MAX_OP(6)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_op_0(req_op_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_op_1(req_op_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(f_rsp_data), .rsp_err(f_rsp_err),
    .alu_op(f_alu_op), .alu_op_a(f_alu_op_a), .alu_op_b(f_alu_op_b), .alu_result(f_alu_result));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a, b, data;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_port(input logic p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p) begin req_op_1 = op; req_a_1 = a; req_b_1 = b; end
    else   begin req_op_0 = op; req_a_0 = a; req_b_0 = b; end
  endtask

  task automatic wait_ready(input string nm, input logic [1:0] want, input bit fp);
    int k = 0;
    #1;
    while (((fp ? f_req_ready : req_ready) != want) && k < 20) begin
      cyc();
      k++;
    end
    chk(nm, fp ? f_req_ready : req_ready, want);
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = v.port ? 2'b10 : 2'b01;
    set_port(v.port, v.op, v.a, v.b);
    req_valid = oh;
    rsp_ready = 2'b00;
    wait_ready("vec_ready", oh, 1'b0);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("vec_exec_rsp_valid", rsp_valid, 2'b00);
    chk("vec_alu_op", alu_op, v.op);
    chk("vec_alu_a", alu_op_a, v.a);
    chk("vec_alu_b", alu_op_b, v.b);
    cyc();
    chk("vec_rsp_valid", rsp_valid, oh);
    chk("vec_rsp_data", rsp_data, v.data);
    chk("vec_rsp_err", rsp_err, v.err);
    rsp_ready = oh;
    cyc();
    rsp_ready = 2'b00;
    #1;
    chk("vec_rsp_drop", rsp_valid, 2'b00);
  endtask

  initial begin
    vec_t        vecs[10];
    logic [31:0] held;
    logic [1:0]  exp_rdy, exp_oh;
    logic [32:0] e;
    logic        busy, port, ptr, g;
    logic [31:0] ed;
    logic        ee;
    int          age;
    logic [3:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 4'd0, 32'hffffffff, 32'h1,        32'h0,        1'b0};
    vecs[1] = '{1'b1, 4'd1, 32'h0,        32'h1,        32'hffffffff, 1'b0};
    vecs[2] = '{1'b0, 4'd2, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0};
    vecs[3] = '{1'b1, 4'd3, 32'h0f0f0000, 32'h000000f0, 32'h0f0f00f0, 1'b0};
    vecs[4] = '{1'b0, 4'd4, 32'haaaaaaaa, 32'hffffffff, 32'h55555555, 1'b0};
    vecs[5] = '{1'b1, 4'd5, 32'h1,        32'd35,       32'h8,        1'b0};
    vecs[6] = '{1'b0, 4'd6, 32'h80000000, 32'd31,       32'h1,        1'b0};
    vecs[7] = '{1'b1, 4'd7, 32'h5,        32'h6,        32'h0,        1'b1};
    vecs[8] = '{1'b0, 4'ha, 32'h1234,     32'h1,        32'h0,        1'b1};
    vecs[9] = '{1'b0, 4'hf, 32'hffffffff, 32'hffffffff, 32'h0,        1'b1};

    req_op_0 = '0; req_a_0 = '0; req_b_0 = '0;
    req_op_1 = '0; req_a_1 = '0; req_b_1 = '0;

    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("reset_req_ready", req_ready, 2'b00);
      chk("reset_rsp_valid", rsp_valid, 2'b00);
      chk("reset_rsp_data", rsp_data, 32'h0);
      chk("reset_alu_op", alu_op, 4'h0);
    end
    rst = 1'b0;
    req_valid = 2'b00;
    cyc();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    do_reset();
    set_port(1'b0, 4'd1, 32'd5, 32'd3);
    set_port(1'b1, 4'd5, 32'd1, 32'd35);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = k[0] ? 2'b10 : 2'b01;
      wait_ready("rr_grant", exp_oh, 1'b0);
      cyc();
      chk("rr_exec_ready", req_ready, 2'b00);
      cyc();
      chk("rr_rsp_valid", rsp_valid, exp_oh);
      chk("rr_rsp_data", rsp_data, k[0] ? 32'h8 : 32'h2);
      chk("rr_resp_no_accept", req_ready, 2'b00);
      cyc();
    end
    req_valid = 2'b00;

    do_reset();
    set_port(1'b0, 4'd0, 32'd1, 32'd2);
    set_port(1'b1, 4'd1, 32'd9, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ready("fp_grant0", 2'b01, 1'b1);
      cyc();
      cyc();
      chk("fp_rsp_valid", f_rsp_valid, 2'b01);
      chk("fp_rsp_data", f_rsp_data, 32'h3);
      if (k == 3) req_valid = 2'b10;
      cyc();
    end
    wait_ready("fp_grant1", 2'b10, 1'b1);
    cyc();
    cyc();
    chk("fp_rsp1_valid", f_rsp_valid, 2'b10);
    chk("fp_rsp1_data", f_rsp_data, 32'h5);
    req_valid = 2'b00;
    cyc();

    do_reset();
    set_port(1'b1, 4'd4, 32'h12345678, 32'hffff0000);
    req_valid = 2'b10;
    wait_ready("bp_ready", 2'b10, 1'b0);
    cyc();
    set_port(1'b0, 4'd0, 32'd7, 32'd8);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    cyc();
    held = rsp_data;
    chk("bp_data", held, 32'hedcb5678);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_hold", rsp_valid, 2'b10);
      chk("bp_data_hold", rsp_data, held);
      chk("bp_no_ready", req_ready, 2'b00);
      cyc();
    end
    rsp_ready = 2'b10;
    #1;
    chk("bp_valid_6th", rsp_valid, 2'b10);
    cyc();
    chk("bp_drop", rsp_valid, 2'b00);
    chk("bp_idle_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cyc();

    set_port(1'b0, 4'd4, 32'h3, 32'h5);
    req_valid = 2'b01;
    wait_ready("mr_ready", 2'b01, 1'b0);
    cyc();
    rst = 1'b1;
    req_valid = 2'b00;
    cyc();
    chk("mr_rsp_valid", rsp_valid, 2'b00);
    chk("mr_rsp_data", rsp_data, 32'h0);
    chk("mr_rsp_err", rsp_err, 32'h0);
    chk("mr_alu_op", alu_op, 4'h0);
    chk("mr_alu_a", alu_op_a, 32'h0);
    chk("mr_alu_b", alu_op_b, 32'h0);
    rst = 1'b0;
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("mr_no_rsp", rsp_valid, 2'b00);
    end
    req_valid = 2'b01;
    #1;
    chk("mr_idle_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    do_reset();
    busy = 1'b0; port = 1'b0; ptr = 1'b0; g = 1'b0; age = 0; ed = '0; ee = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          op = 4'($urandom_range(0, 8));
          a = $urandom;
          b = $urandom;
          set_port(i[0], op, a, b);
          req_valid[i] = 1'b1;
        end
      rsp_ready = 2'($urandom_range(0, 3));
      #1;
      exp_rdy = 2'b00;
      if (!busy && |req_valid) begin
        g = &req_valid ? ptr : req_valid[1];
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      chk("rand_req_ready", req_ready, exp_rdy);
      chk("rand_rsp_valid", rsp_valid, (busy && age >= 1) ? (port ? 2'b10 : 2'b01) : 2'b00);
      if (busy && age >= 1) begin
        chk("rand_rsp_data", rsp_data, ed);
        chk("rand_rsp_err", rsp_err, ee);
      end
      if (exp_rdy != 2'b00) begin
        e = g ? expect_rsp(req_op_1, req_a_1, req_b_1) : expect_rsp(req_op_0, req_a_0, req_b_0);
        {ee, ed} = e;
        busy = 1'b1;
        age = 0;
        port = g;
        ptr = ~g;
      end else if (busy) begin
        if (age >= 1 && rsp_ready[port]) busy = 1'b0;
        else age++;
      end
      cyc();
      if (exp_rdy != 2'b00) req_valid[g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
